// File: rtl/poly_reduce_caddq.sv
// Dilithium reduce32 over a 256-coefficient polynomial, LANES coefficients per cycle,
// start/done level handshake. Define POLY_CADDQ_EN to add caddq (outputs in [0, Q-1]).

module poly_reduce_caddq #(
    parameter int LANES = 8,
    parameter int Q     = 8380417
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [8191:0] a_in,
    output logic [8191:0] c_out,
    output logic          done
);

    localparam int NCOEF   = 256;
    localparam int CW      = 32;
    localparam int CHUNKS  = NCOEF / LANES;
    localparam int IDX_W   = $clog2(CHUNKS) + 1;
    localparam int SLICE_W = LANES * CW;

    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(CHUNKS - 1);
    localparam logic signed [63:0] Q_S      = 64'(Q);
    localparam logic signed [63:0] HALF_S   = 64'sd4194304;
`ifdef POLY_CADDQ_EN
    localparam logic [31:0]        Q32      = 32'(Q);
`endif

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_START = 3'd1,
        LOAD       = 3'd2,
        PROC       = 3'd3,
        DONE       = 3'd4
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [IDX_W-1:0]        idx_reg;
    logic [NCOEF*CW-1:0]     buf_reg;
    logic [SLICE_W-1:0]      lane_res;

    // The captured buffer is shifted down one chunk per PROC cycle, so every lane
    // always reads a fixed bit position instead of an idx-driven wide multiplexer.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [63:0] a_ext;
            logic signed [63:0] t_ext;
            logic        [31:0] r32;

            assign a_ext = {{32{buf_reg[gi*CW+CW-1]}}, buf_reg[gi*CW +: CW]};
            assign t_ext = (a_ext + HALF_S) >>> 23;
            assign r32   = 32'(a_ext - t_ext * Q_S);
`ifdef POLY_CADDQ_EN
            assign lane_res[gi*CW +: CW] = r32[31] ? (r32 + Q32) : r32;
`else
            assign lane_res[gi*CW +: CW] = r32;
`endif
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:       state_next = WAIT_START;
            WAIT_START: if (start) state_next = LOAD;
            LOAD:       state_next = PROC;
            PROC:       if (idx_reg == LAST_IDX) state_next = DONE;
            DONE:       if (!start) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            buf_reg   <= '0;
            c_out     <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                LOAD: begin
                    buf_reg <= a_in;
                    c_out   <= '0;
                    idx_reg <= '0;
                end
                PROC: begin
                    buf_reg <= buf_reg >> SLICE_W;
                    idx_reg <= idx_reg + IDX_W'(1);
                    for (int c = 0; c < CHUNKS; c++) begin
                        if (idx_reg == IDX_W'(c)) begin
                            c_out[c*SLICE_W +: SLICE_W] <= lane_res;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_poly_reduce_caddq.sv
// Scoreboard bench for poly_reduce_caddq: a LANES=8 and a LANES=1 instance checked
// against a floor-division reference of reduce32 (plus caddq when POLY_CADDQ_EN is defined).

module tb_poly_reduce_caddq;

    localparam int     NI = 2;
    localparam longint QL = 8380417;

    typedef struct {
        logic [8191:0] poly;
        int            edge0;
        int            lat;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset [NI];
    logic          start [NI];
    logic [8191:0] a_in  [NI];
    logic [8191:0] c_out [NI];
    logic          done  [NI];

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    int   ntxn  = 0;
    bit   done_prev [NI] = '{1'b0, 1'b0};
    exp_t exp_q0 [$];
    exp_t exp_q1 [$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    poly_reduce_caddq #(.LANES(8), .Q(8380417)) dut8 (
        .clock (clock),
        .reset (reset[0]),
        .start (start[0]),
        .a_in  (a_in[0]),
        .c_out (c_out[0]),
        .done  (done[0])
    );

    poly_reduce_caddq #(.LANES(1), .Q(8380417)) dut1 (
        .clock (clock),
        .reset (reset[1]),
        .start (start[1]),
        .a_in  (a_in[1]),
        .c_out (c_out[1]),
        .done  (done[1])
    );

    function automatic int lanes_of(input int k);
        return (k == 0) ? 8 : 1;
    endfunction

    // reduce32 as "subtract Q times round-half-up(a / 2^23)", using floor division.
    function automatic logic [31:0] ref_coef(input logic [31:0] a);
        longint av, x, t, r;
        av = longint'(signed'(a));
        x  = av + 4194304;
        if (x >= 0) t = x / 8388608;
        else        t = -((-x + 8388607) / 8388608);
        r = av - t * QL;
`ifdef POLY_CADDQ_EN
        if (r < 0) r = r + QL;
`endif
        return r[31:0];
    endfunction

    function automatic logic [8191:0] ref_poly(input logic [8191:0] d);
        logic [8191:0] p;
        for (int j = 0; j < 256; j++) p[32*j +: 32] = ref_coef(d[32*j +: 32]);
        return p;
    endfunction

    function automatic logic [31:0] rand_coef();
        int unsigned m;
        int          v;
        int          k;
        m = $urandom_range(0, 3);
        case (m)
            0: v = int'($urandom());
            1: v = int'($urandom_range(0, 16760834)) - 8380417;
            2: begin
                k = int'($urandom_range(0, 511)) - 256;
                v = k * 8388608 + 4194304 + int'($urandom_range(0, 4)) - 2;
            end
            default: v = int'($urandom_range(0, 1000)) - 500;
        endcase
        return v;
    endfunction

    function automatic logic [8191:0] rand_poly();
        logic [8191:0] p;
        for (int j = 0; j < 256; j++) p[32*j +: 32] = rand_coef();
        return p;
    endfunction

    task automatic chk(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d required=%0d", name, got, want);
        end
    endtask

    // Called on a negedge after which the next posedge moves IDLE->WAIT_START,
    // so the accepting edge is the one after that.
    task automatic start_op(input int k, input logic [8191:0] data, input logic [8191:0] expv);
        exp_t e;
        a_in[k]  = data;
        start[k] = 1'b1;
        e.poly   = expv;
        e.edge0  = cyc + 2;
        e.lat    = 2 + 256 / lanes_of(k);
        if (k == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic finish_op(input int k, input int hold);
        int n;
        int limit;
        n     = 0;
        limit = 2 * (256 / lanes_of(k)) + 20;
        while (done[k] !== 1'b1 && n < limit) begin
            @(negedge clock);
            n++;
        end
        if (done[k] !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL done_timeout dut%0d: got done=%b after %0d cycles required 1", k, done[k], n);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            chk($sformatf("done_held dut%0d", k), longint'(done[k]), 1);
        end
        start[k] = 1'b0;
        @(negedge clock);
        chk($sformatf("done_drop dut%0d", k), longint'(done[k]), 0);
    endtask

    task automatic check_txn(input int k);
        exp_t e;
        int   have;
        int   got_lat;
        int   first_bad;
        have = 0;
        if (k == 0) begin
            have = exp_q0.size();
            if (have > 0) e = exp_q0.pop_front();
        end else begin
            have = exp_q1.size();
            if (have > 0) e = exp_q1.pop_front();
        end
        if (have == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done dut%0d: got done=1 required no pending operation", k);
            return;
        end
        ntxn++;
        got_lat = cyc - e.edge0 + 1;
        chk($sformatf("latency dut%0d", k), got_lat, e.lat);
        first_bad = -1;
        for (int j = 255; j >= 0; j--) begin
            if (c_out[k][32*j +: 32] !== e.poly[32*j +: 32]) first_bad = j;
        end
        total++;
        if (first_bad >= 0) begin
            bad++;
            $display("FAIL coeff dut%0d j=%0d: got=%0d required=%0d", k, first_bad,
                     $signed(c_out[k][32*first_bad +: 32]), $signed(e.poly[32*first_bad +: 32]));
        end
        $display("txn %0d dut%0d: done after %0d cycles (want %0d), coefficients %s",
                 ntxn, k, got_lat, e.lat, (first_bad < 0) ? "match" : "differ");
    endtask

    always @(negedge clock) begin
        for (int k = 0; k < NI; k++) begin
            if (done[k] === 1'b1 && !done_prev[k]) check_txn(k);
            done_prev[k] = (done[k] === 1'b1);
        end
    end

    initial begin
        logic [8191:0] ev;
        logic [8191:0] ee;
        logic [8191:0] d;
        logic [8191:0] ramp;

        for (int k = 0; k < NI; k++) begin
            reset[k] = 1'b0;
            start[k] = 1'b0;
            a_in[k]  = '0;
        end
        repeat (3) @(negedge clock);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("reset_done dut%0d", k), longint'(done[k]), 0);
            chk($sformatf("reset_c_out_nonzero_bits dut%0d", k), longint'($countones(c_out[k])), 0);
        end

        // Edge vector with hand-computed expectations.
        ev = '0;
        ev[63:32]   = 32'd8380417;
        ev[95:64]   = 32'hFFFFFFFF;
        ev[127:96]  = 32'h7FFFFFFF;
        ev[159:128] = 32'h80000000;
        ee = '0;
        ee[127:96]  = 32'd2096895;
`ifdef POLY_CADDQ_EN
        ee[95:64]   = 32'd8380416;
        ee[159:128] = 32'd6283521;
`else
        ee[95:64]   = 32'hFFFFFFFF;
        ee[159:128] = 32'(-2096896);
`endif
        reset[0] = 1'b1;
        start_op(0, ev, ee);
        finish_op(0, 0);

        // Handshake: hold start past done, then back-to-back with new data.
        d = rand_poly();
        start_op(0, d, ref_poly(d));
        finish_op(0, 5);
        d = rand_poly();
        start_op(0, d, ref_poly(d));
        finish_op(0, 0);

        // Input isolation: a_in changes after capture and again mid-PROC.
        d = rand_poly();
        start_op(0, d, ref_poly(d));
        repeat (3) @(negedge clock);
        a_in[0] = rand_poly();
        repeat (10) @(negedge clock);
        a_in[0] = rand_poly();
        finish_op(0, 1);

        // Reset mid-PROC with start still high, then a fresh operation.
        d = rand_poly();
        start_op(0, d, ref_poly(d));
        repeat (12) @(negedge clock);
        void'(exp_q0.pop_back());
        reset[0] = 1'b0;
        @(negedge clock);
        chk("midreset_done", longint'(done[0]), 0);
        chk("midreset_c_out_nonzero_bits", longint'($countones(c_out[0])), 0);
        reset[0] = 1'b1;
        d = rand_poly();
        start_op(0, d, ref_poly(d));
        finish_op(0, 0);

        for (int i = 0; i < 4; i++) begin
            d = rand_poly();
            start_op(0, d, ref_poly(d));
            finish_op(0, int'($urandom_range(0, 2)));
        end

        // Single-lane instance with the ramp vector.
        for (int j = 0; j < 256; j++) ramp[32*j +: 32] = 32'(j * 40000 - 5000000);
        reset[1] = 1'b1;
        start_op(1, ramp, ref_poly(ramp));
        finish_op(1, 0);

        repeat (5) @(negedge clock);
        chk("pending_expectations", longint'(exp_q0.size() + exp_q1.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
